control_sequencer: RTL and testbench

Hardwired control unit for the 32-bit bus-based CPU datapath. It drives every datapath strobe: register in/out selects, PC, MAR, MDR, IR, Y, Z, HI and LO enables, and the ALU opcode. It also runs a ready-based handshake with external memory. It sequences fetch and execute as a Moore FSM, decoding register fields from the IR value the datapath feeds back.

---
 rtl/control_sequencer_if.sv | 10 +
 rtl/control_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_control_sequencer.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - memory request/ready handshake between sequencer and memory
`timescale 1ns/1ps
interface control_sequencer_if;
  logic mem_read;
  logic mem_write;
  logic mem_ready;

  modport master (output mem_read, output mem_write, input mem_ready);
  modport slave  (input mem_read, input mem_write, output mem_ready);
endinterface

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired Moore control unit for the bus-based CPU datapath
`timescale 1ns/1ps
module control_sequencer (
  input  logic                       clk,
  input  logic                       clr,
  input  logic [31:0]                IR,
  control_sequencer_if.master        mem,
  output logic [15:0]                Rin,
  output logic [15:0]                Rout,
  output logic                       PCout,
  output logic                       IncPC,
  output logic                       MARin,
  output logic                       MDRin,
  output logic                       MDRread,
  output logic                       MDRout,
  output logic                       IRin,
  output logic                       Yin,
  output logic                       Zin,
  output logic                       ZLOout,
  output logic                       ZHIout,
  output logic                       HIin,
  output logic                       HIout,
  output logic                       Loin,
  output logic                       Loout,
  output logic                       Cout,
  output logic [4:0]                 ALU_opcode,
  output logic                       run,
  output logic                       illegal_op
);

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7,
    S_MWAIT_R, S_MWAIT_W, S_HALT
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_mem_read;
  logic        w_mem_write;
  logic [4:0]  w_op;
  logic [3:0]  w_ra, w_rb, w_rc;
  logic        w_is_alu, w_is_imm, w_is_ld, w_is_st, w_is_md;
  logic        w_is_mfhi, w_is_mflo, w_is_nop, w_is_halt, w_is_legal;
  logic [4:0]  w_imm_alu;
  logic        w_unused;

  assign w_op     = IR[31:27];
  assign w_ra     = IR[26:23];
  assign w_rb     = IR[22:19];
  assign w_rc     = IR[18:15];
  assign w_unused = ^IR[14:0];

  assign w_is_alu   = (w_op >= 5'd3) && (w_op <= 5'd10);
  assign w_is_imm   = (w_op == 5'd1) || ((w_op >= 5'd12) && (w_op <= 5'd14));
  assign w_is_ld    = (w_op == 5'd0);
  assign w_is_st    = (w_op == 5'd2);
  assign w_is_md    = (w_op == 5'd15) || (w_op == 5'd16);
  assign w_is_mfhi  = (w_op == 5'd19);
  assign w_is_mflo  = (w_op == 5'd20);
  assign w_is_nop   = (w_op == 5'd26);
  assign w_is_halt  = (w_op == 5'd27);
  assign w_is_legal = w_is_alu | w_is_imm | w_is_ld | w_is_st | w_is_md |
                      w_is_mfhi | w_is_mflo | w_is_nop | w_is_halt;

  // ldi and addi both reduce to an add of the sign-extended constant
  assign w_imm_alu = (w_op == 5'd13) ? 5'd5 :
                     (w_op == 5'd14) ? 5'd6 : 5'd3;

  assign mem.mem_read  = w_mem_read;
  assign mem.mem_write = w_mem_write;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) r_state <= S_RESET;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    Rin         = '0;
    Rout        = '0;
    PCout       = 1'b0;
    IncPC       = 1'b0;
    MARin       = 1'b0;
    MDRin       = 1'b0;
    MDRread     = 1'b0;
    MDRout      = 1'b0;
    IRin        = 1'b0;
    Yin         = 1'b0;
    Zin         = 1'b0;
    ZLOout      = 1'b0;
    ZHIout      = 1'b0;
    HIin        = 1'b0;
    HIout       = 1'b0;
    Loin        = 1'b0;
    Loout       = 1'b0;
    Cout        = 1'b0;
    ALU_opcode  = 5'd0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    illegal_op  = 1'b0;
    run         = (r_state != S_RESET) && (r_state != S_HALT);

    case (r_state)
      S_RESET: w_next = S_T0;
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1;
        w_next = S_T1;
      end
      S_T1: begin
        w_mem_read = 1'b1; MDRread = 1'b1; MDRin = mem.mem_ready;
        if (mem.mem_ready) w_next = S_T2;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        w_next = S_T3;
      end
      S_T3: begin
        w_next = S_T4;
        if (w_is_alu || w_is_imm || w_is_ld || w_is_st) begin
          Rout = 16'h0001 << w_rb; Yin = 1'b1;
        end else if (w_is_md) begin
          Rout = 16'h0001 << w_ra; Yin = 1'b1;
        end else if (w_is_mfhi || w_is_mflo) begin
          HIout = w_is_mfhi; Loout = w_is_mflo; Rin = 16'h0001 << w_ra;
          w_next = S_T0;
        end else if (w_is_halt) begin
          w_next = S_HALT;
        end else begin
          illegal_op = !w_is_legal;
          w_next = S_T0;
        end
      end
      S_T4: begin
        w_next = S_T5;
        Zin = 1'b1;
        if (w_is_alu) begin
          Rout = 16'h0001 << w_rc; ALU_opcode = w_op;
        end else if (w_is_imm) begin
          Cout = 1'b1; ALU_opcode = w_imm_alu;
        end else if (w_is_ld || w_is_st) begin
          Cout = 1'b1; ALU_opcode = 5'd3;
        end else if (w_is_md) begin
          Rout = 16'h0001 << w_rb; ALU_opcode = w_op;
        end else begin
          Zin = 1'b0; w_next = S_T0;
        end
      end
      S_T5: begin
        w_next = S_T0;
        if (w_is_alu || w_is_imm) begin
          ZLOout = 1'b1; Rin = 16'h0001 << w_ra;
        end else if (w_is_ld || w_is_st) begin
          ZLOout = 1'b1; MARin = 1'b1;
          w_next = w_is_ld ? S_MWAIT_R : S_T6;
        end else if (w_is_md) begin
          ZLOout = 1'b1; Loin = 1'b1; w_next = S_T6;
        end
      end
      S_T6: begin
        w_next = S_T0;
        if (w_is_ld) begin
          MDRout = 1'b1; Rin = 16'h0001 << w_ra;
        end else if (w_is_st) begin
          Rout = 16'h0001 << w_ra; MDRin = 1'b1; w_next = S_MWAIT_W;
        end else if (w_is_md) begin
          ZHIout = 1'b1; HIin = 1'b1;
        end
      end
      S_MWAIT_R: begin
        w_mem_read = 1'b1; MDRread = 1'b1; MDRin = mem.mem_ready;
        if (mem.mem_ready) w_next = S_T6;
      end
      S_MWAIT_W: begin
        w_mem_write = 1'b1;
        if (mem.mem_ready) w_next = S_T0;
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_T0;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - self-checking bench for control_sequencer
`timescale 1ns/1ps
module tb_control_sequencer;

  typedef struct packed {
    logic [15:0] rin;
    logic [15:0] rout;
    logic pcout, incpc, marin, mdrin, mdrread, mdrout, irin, yin;
    logic zin, zloout, zhiout, hiin, hiout, loin, loout, cout;
    logic [4:0] alu;
    logic mem_read, mem_write, run, illegal;
  } outs_t;

  typedef struct {
    outs_t exp;
    logic  rdy;
    logic  exe;
  } cyc_t;

  typedef struct {
    logic [31:0] ir;
    int          fw, mw, cyc;
    logic [15:0] rin, rout;
    logic [4:0]  alu;
    int          rd, wr, ill;
  } tbl_t;

  logic clk = 1'b0;
  logic clr;
  logic [31:0] IR;
  logic [15:0] Rin, Rout;
  logic PCout, IncPC, MARin, MDRin, MDRread, MDRout, IRin, Yin, Zin;
  logic ZLOout, ZHIout, HIin, HIout, Loin, Loout, Cout, run, illegal_op;
  logic [4:0] ALU_opcode;
  outs_t act;
  int checks = 0;
  int failures = 0;
  cyc_t q[$];
  tbl_t tbl[12];

  control_sequencer_if u_if ();

  control_sequencer dut (
    .clk(clk), .clr(clr), .IR(IR), .mem(u_if.master),
    .Rin(Rin), .Rout(Rout), .PCout(PCout), .IncPC(IncPC), .MARin(MARin),
    .MDRin(MDRin), .MDRread(MDRread), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
    .Zin(Zin), .ZLOout(ZLOout), .ZHIout(ZHIout), .HIin(HIin), .HIout(HIout),
    .Loin(Loin), .Loout(Loout), .Cout(Cout), .ALU_opcode(ALU_opcode),
    .run(run), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  assign act = {Rin, Rout, PCout, IncPC, MARin, MDRin, MDRread, MDRout, IRin, Yin,
                Zin, ZLOout, ZHIout, HIin, HIout, Loin, Loout, Cout, ALU_opcode,
                u_if.mem_read, u_if.mem_write, run, illegal_op};

  task automatic check(input string name, input longint a, input longint e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, a, e);
    end
  endtask

  function automatic outs_t base();
    outs_t o = '0;
    o.run = 1'b1;
    return o;
  endfunction

  function automatic outs_t t0_vec();
    outs_t o = base();
    o.pcout = 1'b1; o.marin = 1'b1; o.incpc = 1'b1;
    return o;
  endfunction

  task automatic push(input outs_t o, input logic rdy, input logic exe);
    cyc_t c;
    c.exp = o; c.rdy = rdy; c.exe = exe;
    q.push_back(c);
  endtask

  // Expected cycle-by-cycle strobe list for one instruction, from the opcode step tables
  task automatic build(input logic [31:0] ir, input int fw, input int mw);
    logic [4:0] op = ir[31:27];
    logic [15:0] ra = 16'h0001 << ir[26:23];
    logic [15:0] rb = 16'h0001 << ir[22:19];
    logic [15:0] rc = 16'h0001 << ir[18:15];
    outs_t o;
    q.delete();
    push(t0_vec(), 1'($urandom_range(0, 1)), 1'b0);
    for (int i = 0; i <= fw; i++) begin
      o = base(); o.mem_read = 1; o.mdrread = 1; o.mdrin = (i == fw);
      push(o, i == fw, 1'b0);
    end
    o = base(); o.mdrout = 1; o.irin = 1;
    push(o, 1'($urandom_range(0, 1)), 1'b0);
    case (op) inside
      [5'd3:5'd10], 5'd1, [5'd12:5'd14]: begin
        o = base(); o.rout = rb; o.yin = 1; push(o, 1'($urandom_range(0, 1)), 1'b1);
        o = base(); o.zin = 1;
        if (op >= 5'd3 && op <= 5'd10) begin o.rout = rc; o.alu = op; end
        else begin o.cout = 1; o.alu = (op == 5'd13) ? 5'd5 : (op == 5'd14) ? 5'd6 : 5'd3; end
        push(o, 1'($urandom_range(0, 1)), 1'b1);
        o = base(); o.zloout = 1; o.rin = ra; push(o, 1'($urandom_range(0, 1)), 1'b1);
      end
      5'd0, 5'd2: begin
        o = base(); o.rout = rb; o.yin = 1; push(o, 1'($urandom_range(0, 1)), 1'b1);
        o = base(); o.cout = 1; o.alu = 5'd3; o.zin = 1; push(o, 1'($urandom_range(0, 1)), 1'b1);
        o = base(); o.zloout = 1; o.marin = 1; push(o, 1'($urandom_range(0, 1)), 1'b1);
        if (op == 5'd0) begin
          for (int i = 0; i <= mw; i++) begin
            o = base(); o.mem_read = 1; o.mdrread = 1; o.mdrin = (i == mw);
            push(o, i == mw, 1'b1);
          end
          o = base(); o.mdrout = 1; o.rin = ra; push(o, 1'($urandom_range(0, 1)), 1'b1);
        end else begin
          o = base(); o.rout = ra; o.mdrin = 1; push(o, 1'($urandom_range(0, 1)), 1'b1);
          for (int i = 0; i <= mw; i++) begin
            o = base(); o.mem_write = 1; push(o, i == mw, 1'b1);
          end
        end
      end
      5'd15, 5'd16: begin
        o = base(); o.rout = ra; o.yin = 1; push(o, 1'($urandom_range(0, 1)), 1'b1);
        o = base(); o.rout = rb; o.alu = op; o.zin = 1; push(o, 1'($urandom_range(0, 1)), 1'b1);
        o = base(); o.zloout = 1; o.loin = 1; push(o, 1'($urandom_range(0, 1)), 1'b1);
        o = base(); o.zhiout = 1; o.hiin = 1; push(o, 1'($urandom_range(0, 1)), 1'b1);
      end
      5'd19, 5'd20: begin
        o = base(); o.hiout = (op == 5'd19); o.loout = (op == 5'd20); o.rin = ra;
        push(o, 1'($urandom_range(0, 1)), 1'b1);
      end
      5'd26: push(base(), 1'($urandom_range(0, 1)), 1'b1);
      5'd27: begin
        push(base(), 1'($urandom_range(0, 1)), 1'b1);
        for (int i = 0; i < 20; i++) push('0, 1'($urandom_range(0, 1)), 1'b1);
      end
      default: begin
        o = base(); o.illegal = 1; push(o, 1'($urandom_range(0, 1)), 1'b1);
      end
    endcase
  endtask

  // Entered at posedge+1 of a T0 cycle; leaves at posedge+1 after the last modelled cycle
  task automatic run_model(input logic [31:0] ir, input int idx);
    int bad_at = -1;
    outs_t bad_act = '0;
    for (int i = 0; i < q.size(); i++) begin
      u_if.mem_ready = q[i].rdy;
      IR = q[i].exe ? ir : $urandom();
      @(negedge clk);
      if (act !== q[i].exp && bad_at < 0) begin bad_at = i; bad_act = act; end
      @(posedge clk); #1;
    end
    checks++;
    if (bad_at >= 0) begin
      failures++;
      $display("FAIL model instr=%0d ir=%h cycle=%0d actual=%h expected=%h",
               idx, ir, bad_at, bad_act, q[bad_at].exp);
    end
  endtask

  task automatic rand_instrs(input int n, input int base_idx);
    logic [31:0] r, ir;
    logic [4:0] op;
    for (int k = 0; k < n; k++) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'd27) op = 5'd26;
      r = $urandom();
      ir = {op, r[26:0]};
      build(ir, $urandom_range(0, 3), $urandom_range(0, 3));
      run_model(ir, base_idx + k);
    end
  endtask

  task automatic run_tbl(input tbl_t t, input int idx);
    int n = 0, ep = 0, wc = 0, rd = 0, wr = 0, ill = 0;
    logic prev = 1'b0;
    logic [15:0] rin_or = '0, rout_or = '0;
    logic [4:0] alu_or = '0;
    IR = t.ir;
    do begin
      if (u_if.mem_read || u_if.mem_write) begin
        if (!prev) begin wc = (ep == 0) ? t.fw : t.mw; ep++; end
        u_if.mem_ready = (wc == 0);
        if (wc > 0) wc--;
        prev = 1'b1;
      end else begin
        u_if.mem_ready = 1'($urandom_range(0, 1));
        prev = 1'b0;
      end
      @(negedge clk);
      rin_or |= Rin; rout_or |= Rout; alu_or |= ALU_opcode;
      rd += int'(u_if.mem_read); wr += int'(u_if.mem_write); ill += int'(illegal_op);
      n++;
      @(posedge clk); #1;
    end while (!PCout && n < 40);
    check($sformatf("tbl%0d_cycles", idx), n, t.cyc);
    check($sformatf("tbl%0d_rin", idx), rin_or, t.rin);
    check($sformatf("tbl%0d_rout", idx), rout_or, t.rout);
    check($sformatf("tbl%0d_alu", idx), alu_or, t.alu);
    check($sformatf("tbl%0d_rd", idx), rd, t.rd);
    check($sformatf("tbl%0d_wr", idx), wr, t.wr);
    check($sformatf("tbl%0d_ill", idx), ill, t.ill);
  endtask

  initial begin
    #300000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    tbl[0]  = '{32'h18918000, 0, 0, 6,  16'h0002, 16'h000C, 5'h03, 1, 0, 0};
    tbl[1]  = '{32'h18918000, 2, 0, 8,  16'h0002, 16'h000C, 5'h03, 3, 0, 0};
    tbl[2]  = '{32'h02100005, 0, 2, 10, 16'h0010, 16'h0004, 5'h03, 4, 0, 0};
    tbl[3]  = '{32'h7AB00000, 0, 0, 7,  16'h0000, 16'h0060, 5'h0F, 1, 0, 0};
    tbl[4]  = '{32'h11880000, 1, 1, 10, 16'h0000, 16'h000A, 5'h03, 2, 2, 0};
    tbl[5]  = '{32'h9B800000, 0, 0, 4,  16'h0080, 16'h0000, 5'h00, 1, 0, 0};
    tbl[6]  = '{32'h6CD00000, 0, 0, 6,  16'h0200, 16'h0400, 5'h05, 1, 0, 0};
    tbl[7]  = '{32'hB0000000, 0, 0, 4,  16'h0000, 16'h0000, 5'h00, 1, 0, 1};
    tbl[8]  = '{32'hD0000000, 0, 0, 4,  16'h0000, 16'h0000, 5'h00, 1, 0, 0};
    tbl[9]  = '{32'h0F800000, 0, 0, 6,  16'h8000, 16'h0001, 5'h03, 1, 0, 0};
    tbl[10] = '{32'h81180000, 3, 0, 10, 16'h0000, 16'h000C, 5'h10, 4, 0, 0};
    tbl[11] = '{32'hA0000000, 0, 0, 4,  16'h0001, 16'h0000, 5'h00, 1, 0, 0};

    clr = 1'b0;
    IR = 32'h0;
    u_if.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("reset_outputs_%0d", i), act, 0);
    end
    clr = 1'b1;
    #1 check("reset_before_edge", act, 0);
    @(posedge clk); #1;
    check("reset_release_t0", act, t0_vec());

    for (int i = 0; i < 12; i++) run_tbl(tbl[i], i);

    rand_instrs(80, 0);

    build(32'hD8000000, $urandom_range(0, 3), 0);
    run_model(32'hD8000000, 1000);
    clr = 1'b0;
    #1 check("halt_clr_outputs", act, 0);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk); #1;
    check("halt_exit_t0", act, t0_vec());

    IR = 32'h11880000;
    n = 0;
    while (!u_if.mem_write && n < 30) begin
      u_if.mem_ready = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    u_if.mem_ready = 1'b0;
    check("st_reach_mwait_w", u_if.mem_write, 1);
    #2 clr = 1'b0;
    #1 check("async_clr_drop", act, 0);
    @(posedge clk); #1;
    check("clr_held", act, 0);
    @(negedge clk);
    clr = 1'b1;
    u_if.mem_ready = 1'b1;
    @(posedge clk); #1;
    check("post_clr_t0", act, t0_vec());

    rand_instrs(10, 2000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
